// File: rtl/load_width_reducer_if.sv
// Bundle of the load-width-reducer pipeline stage signals.
//   master: drives en, flush, in_valid, base_result, width_src; observes the results.
//   slave : the reducer stage itself; drives result, out_valid, illegal_width.
interface load_width_reducer_if #(
    parameter int unsigned DATA_W = 32
);
    logic              en;            // 0 = stall, registered outputs hold
    logic              flush;         // bubble insert, clears valid/illegal
    logic              in_valid;      // base_result/width_src valid this cycle
    logic [DATA_W-1:0] base_result;   // raw loaded word
    logic [2:0]        width_src;     // load width / signedness code
    logic [DATA_W-1:0] result;        // reduced and extended value
    logic              out_valid;     // result valid
    logic              illegal_width; // captured width_src was unsupported

    modport master (
        output en, flush, in_valid, base_result, width_src,
        input  result, out_valid, illegal_width
    );

    modport slave (
        input  en, flush, in_valid, base_result, width_src,
        output result, out_valid, illegal_width
    );
endinterface

// File: rtl/load_width_reducer.sv
// Load-data width reduction stage on the writeback path.
// Extracts the least-significant byte/halfword (or the whole word) of the loaded data,
// sign- or zero-extends it, and registers the result with valid tracking, stall and flush.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : load_width_reducer_if.slave (en, flush, in_valid, base_result, width_src in;
//             result, out_valid, illegal_width out, all registered)
module load_width_reducer #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    load_width_reducer_if.slave    bus
);

    localparam logic [2:0] WIDTH_W  = 3'b000;
    localparam logic [2:0] WIDTH_H  = 3'b010;
    localparam logic [2:0] WIDTH_HU = 3'b110;
    localparam logic [2:0] WIDTH_B  = 3'b001;
    localparam logic [2:0] WIDTH_BU = 3'b101;

    logic [DATA_W-1:0] w_reduced;
    logic              w_illegal;

    logic [DATA_W-1:0] r_result;
    logic              r_out_valid;
    logic              r_illegal;

    // Width decode; only the low lane is used, alignment happens upstream.
    always_comb begin
        w_reduced = '0;
        w_illegal = 1'b0;
        case (bus.width_src)
            WIDTH_W:  w_reduced = bus.base_result;
            WIDTH_H:  w_reduced = {{(DATA_W-16){bus.base_result[15]}}, bus.base_result[15:0]};
            WIDTH_HU: w_reduced = {{(DATA_W-16){1'b0}}, bus.base_result[15:0]};
            WIDTH_B:  w_reduced = {{(DATA_W-8){bus.base_result[7]}}, bus.base_result[7:0]};
            WIDTH_BU: w_reduced = {{(DATA_W-8){1'b0}}, bus.base_result[7:0]};
            default:  w_illegal = 1'b1;
        endcase
    end

    // Flush beats stall so a bubble can be inserted while the stage is held.
    // result keeps updating while in_valid=0; consumers qualify with out_valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (bus.en) begin
            r_result    <= w_reduced;
            r_out_valid <= bus.in_valid;
            r_illegal   <= w_illegal & bus.in_valid;
        end
    end

    assign bus.result        = r_result;
    assign bus.out_valid     = r_out_valid;
    assign bus.illegal_width = r_illegal;

endmodule

// File: tb/tb_load_width_reducer.sv
// Directed bench for load_width_reducer: expected outputs are queued when each input is
// driven and popped for comparison one clock later.
module tb_load_width_reducer;

    logic clk;
    logic reset_n;

    load_width_reducer_if #(.DATA_W(32)) u_if ();

    load_width_reducer #(.DATA_W(32)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] result;
        logic        valid;
        logic        illegal;
    } exp_t;

    exp_t exp_q[$];

    // Expected register state (what the stage should hold after the next edge)
    logic [31:0] m_result;
    logic        m_valid;
    logic        m_illegal;

    int n_checks;
    int n_pass;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        assert (act === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, act, exp);
    endtask

    // One clock of stimulus. r_exp/ill_exp are the reduced value and illegal flag the
    // stage must compute for (b, w); hold/flush behaviour is tracked by the model state.
    task automatic step(input string tag, input logic en_v, input logic flush_v,
                        input logic vld, input logic [31:0] b, input logic [2:0] w,
                        input logic [31:0] r_exp, input logic ill_exp);
        exp_t e;
        exp_t got;
        u_if.en          = en_v;
        u_if.flush       = flush_v;
        u_if.in_valid    = vld;
        u_if.base_result = b;
        u_if.width_src   = w;
        if (flush_v) begin
            m_valid   = 1'b0;
            m_illegal = 1'b0;
        end else if (en_v) begin
            m_result  = r_exp;
            m_valid   = vld;
            m_illegal = ill_exp & vld;
        end
        e.result  = m_result;
        e.valid   = m_valid;
        e.illegal = m_illegal;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check({tag, ".result"},  u_if.result, got.result);
        check({tag, ".valid"},   {31'b0, u_if.out_valid}, {31'b0, got.valid});
        check({tag, ".illegal"}, {31'b0, u_if.illegal_width}, {31'b0, got.illegal});
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        m_result  = 32'h0;
        m_valid   = 1'b0;
        m_illegal = 1'b0;

        // Reset held while inputs toggle with en=1
        reset_n          = 1'b0;
        u_if.en          = 1'b1;
        u_if.flush       = 1'b0;
        u_if.in_valid    = 1'b1;
        u_if.base_result = 32'hFFFF_FFFF;
        u_if.width_src   = 3'b011;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            u_if.base_result = $urandom;
            u_if.width_src   = 3'($urandom_range(0, 7));
            u_if.in_valid    = ~u_if.in_valid;
        end
        check("rst.result",  u_if.result, 32'h0);
        check("rst.valid",   {31'b0, u_if.out_valid}, 32'h0);
        check("rst.illegal", {31'b0, u_if.illegal_width}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;

        step("word", 1, 0, 1, 32'hDEAD_BEEF, 3'b000, 32'hDEAD_BEEF, 0);

        // Sign / zero extension
        step("lh",  1, 0, 1, 32'h1234_8F7A, 3'b010, 32'hFFFF_8F7A, 0);
        step("lhu", 1, 0, 1, 32'h1234_8F7A, 3'b110, 32'h0000_8F7A, 0);
        step("lb",  1, 0, 1, 32'h1234_8F7A, 3'b001, 32'h0000_007A, 0);
        step("lbu", 1, 0, 1, 32'h1234_8F7A, 3'b101, 32'h0000_007A, 0);

        // Sign-bit boundaries
        step("lb80",   1, 0, 1, 32'h0000_0080, 3'b001, 32'hFFFF_FF80, 0);
        step("lbu80",  1, 0, 1, 32'h0000_0080, 3'b101, 32'h0000_0080, 0);
        step("lh7fff", 1, 0, 1, 32'hFFFF_7FFF, 3'b010, 32'h0000_7FFF, 0);
        step("lhuff",  1, 0, 1, 32'hFFFF_FFFF, 3'b110, 32'h0000_FFFF, 0);

        // Illegal codes, then a legal code clears the flag
        step("ill011", 1, 0, 1, 32'hFFFF_FFFF, 3'b011, 32'h0, 1);
        step("ill100", 1, 0, 1, 32'hFFFF_FFFF, 3'b100, 32'h0, 1);
        step("ill111", 1, 0, 1, 32'hFFFF_FFFF, 3'b111, 32'h0, 1);
        step("illclr", 1, 0, 1, 32'hFFFF_FFFF, 3'b000, 32'hFFFF_FFFF, 0);
        // Illegal code without in_valid must not raise the flag
        step("illnv",  1, 0, 0, 32'hFFFF_FFFF, 3'b111, 32'h0, 1);
        // Flush clears a raised illegal flag and holds result
        step("ill2",   1, 0, 1, 32'h1111_2222, 3'b100, 32'h0, 1);
        step("illfl",  1, 1, 1, 32'h3333_4444, 3'b000, 32'h3333_4444, 0);

        // Stall and flush during stall
        step("load",   1, 0, 1, 32'hA5A5_A5A5, 3'b000, 32'hA5A5_A5A5, 0);
        step("stall1", 0, 0, 1, 32'h1234_5678, 3'b000, 32'h1234_5678, 0);
        step("stall2", 0, 0, 1, 32'h0000_0080, 3'b001, 32'hFFFF_FF80, 0);
        step("flush",  0, 1, 1, 32'h1234_5678, 3'b000, 32'h1234_5678, 0);
        step("stall3", 0, 0, 1, 32'h1234_5678, 3'b000, 32'h1234_5678, 0);

        // Back-to-back streaming, then an invalid slot that still updates result
        step("s0", 1, 0, 1, 32'h0000_0001, 3'b000, 32'h0000_0001, 0);
        step("s1", 1, 0, 1, 32'h0000_00FE, 3'b001, 32'hFFFF_FFFE, 0);
        step("s2", 1, 0, 1, 32'hCAFE_8001, 3'b110, 32'h0000_8001, 0);
        step("s3", 1, 0, 1, 32'h7777_8001, 3'b010, 32'hFFFF_8001, 0);
        step("s4", 1, 0, 1, 32'h0000_01FF, 3'b101, 32'h0000_00FF, 0);
        step("nv", 1, 0, 0, 32'h0BAD_F00D, 3'b000, 32'h0BAD_F00D, 0);
        step("s5", 1, 0, 1, 32'h5555_AAAA, 3'b000, 32'h5555_AAAA, 0);

        // Asynchronous reset mid-cycle takes effect without a clock edge
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("arst.result",  u_if.result, 32'h0);
        check("arst.valid",   {31'b0, u_if.out_valid}, 32'h0);
        check("arst.illegal", {31'b0, u_if.illegal_width}, 32'h0);
        @(negedge clk);
        reset_n   = 1'b1;
        m_result  = 32'h0;
        m_valid   = 1'b0;
        m_illegal = 1'b0;
        #1;
        step("post", 1, 0, 1, 32'h8000_0000, 3'b000, 32'h8000_0000, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
